// File: rtl/seq_driver.sv
`default_nettype none
// ============================================================================
// Module      : seq_driver
// Description : Sequencer-to-driver bridge. Items are buffered in a small FIFO
//               and replayed as single-cycle beats with a fixed idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_driver #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int GAP    = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] seq_data,
    input  logic              seq_valid,
    output logic              seq_ready,
    output logic [DATA_W-1:0] driver_data,
    output logic              driver_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  sent_count
);

    localparam int                 C_PTR_W    = $clog2(DEPTH);
    localparam logic [C_PTR_W:0]   C_DEPTH    = (C_PTR_W + 1)'(DEPTH);
    localparam logic [3:0]         C_GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [C_PTR_W-1:0]  r_wr_ptr;
    logic [C_PTR_W-1:0]  r_rd_ptr;
    logic [C_PTR_W:0]    r_count;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [3:0]          r_gap_cnt;
    logic                w_push;
    logic                w_pop;
    logic                w_has_item;
    logic                w_gap_load;
    logic                w_gap_dec;

    // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot early.
    assign seq_ready  = (r_count < C_DEPTH) && !rst;
    assign w_push     = seq_valid && seq_ready;
    assign w_has_item = (r_count != '0);
    assign busy       = (r_state != ST_IDLE) || w_has_item;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= seq_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_gap_load   = 1'b0;
        w_gap_dec    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_has_item) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (GAP > 0) begin
                    w_gap_load   = 1'b1;
                    w_next_state = ST_GAP;
                end else if (w_has_item) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_DRIVE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    if (w_has_item) begin
                        w_pop        = 1'b1;
                        w_next_state = ST_DRIVE;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_gap_dec = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap_cnt <= 4'd0;
        end else if (w_gap_load) begin
            r_gap_cnt <= C_GAP_LOAD;
        end else if (w_gap_dec) begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
        end
    end

    // A pop always leads into DRIVE, so the beat registers load on the pop edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            driver_valid <= 1'b0;
            driver_data  <= '0;
            sent_count   <= '0;
        end else begin
            driver_valid <= w_pop;
            driver_data  <= w_pop ? r_mem[r_rd_ptr] : '0;
            if (w_pop) begin
                sent_count <= sent_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_driver
// Description : Self-checking bench; three seq_driver instances (GAP=1,2,0)
//               compared cycle by cycle against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_driver;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  sd  [3];
    logic        sv  [3];
    logic        rdy [3];
    logic        dv  [3];
    logic [7:0]  dd  [3];
    logic        bz  [3];
    logic [15:0] sc_a;
    logic [15:0] sc_b;
    logic [3:0]  sc_c;

    always #5 clk = ~clk;

    seq_driver #(.DATA_W(8), .DEPTH(DEPTH), .GAP(1), .CNT_W(16)) u_g1 (
        .clk(clk), .rst(rst), .seq_data(sd[0]), .seq_valid(sv[0]), .seq_ready(rdy[0]),
        .driver_data(dd[0]), .driver_valid(dv[0]), .busy(bz[0]), .sent_count(sc_a));
    seq_driver #(.DATA_W(8), .DEPTH(DEPTH), .GAP(2), .CNT_W(16)) u_g2 (
        .clk(clk), .rst(rst), .seq_data(sd[1]), .seq_valid(sv[1]), .seq_ready(rdy[1]),
        .driver_data(dd[1]), .driver_valid(dv[1]), .busy(bz[1]), .sent_count(sc_b));
    seq_driver #(.DATA_W(8), .DEPTH(DEPTH), .GAP(0), .CNT_W(4)) u_g0 (
        .clk(clk), .rst(rst), .seq_data(sd[2]), .seq_valid(sv[2]), .seq_ready(rdy[2]),
        .driver_data(dd[2]), .driver_valid(dv[2]), .busy(bz[2]), .sent_count(sc_c));

    // Reference model: queued items, items still to offer, and cycles since the last beat.
    logic [7:0] mq  [3][$];
    logic [7:0] src [3][$];
    int         idle_run [3];
    int         exp_sent [3];
    logic       exp_dv   [3];
    logic [7:0] exp_dd   [3];
    int         full_seen [3];
    bit         rand_mode = 1'b0;
    int         total = 0;
    int         bad   = 0;

    function automatic int gap_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 0;
    endfunction

    function automatic int cw_of(input int k);
        return (k == 2) ? 4 : 16;
    endfunction

    function automatic logic [31:0] sent_of(input int k);
        case (k)
            0:       return {16'd0, sc_a};
            1:       return {16'd0, sc_b};
            default: return {28'd0, sc_c};
        endcase
    endfunction

    function automatic bit all_idle();
        for (int k = 0; k < 3; k++) begin
            if (src[k].size() != 0 || mq[k].size() != 0 || idle_run[k] <= gap_of(k)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            src[k].delete();
            idle_run[k] = 100;
            exp_sent[k] = 0;
            exp_dv[k]   = 1'b0;
            exp_dd[k]   = 8'h00;
            sv[k]       = 1'b0;
            sd[k]       = 8'h00;
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_g%0d_valid", tag, gap_of(k)), dv[k], 0);
            chk($sformatf("%s_g%0d_data", tag, gap_of(k)), dd[k], 0);
            chk($sformatf("%s_g%0d_sent", tag, gap_of(k)), sent_of(k), 0);
            chk($sformatf("%s_g%0d_busy", tag, gap_of(k)), bz[k], 0);
            chk($sformatf("%s_g%0d_ready", tag, gap_of(k)), rdy[k], 0);
        end
    endtask

    // One clock: offer, check ready, advance the model at the edge, check outputs at negedge.
    task automatic step();
        bit push [3];
        for (int k = 0; k < 3; k++) begin
            sv[k] = (src[k].size() > 0) && (!rand_mode || $urandom_range(0, 1) == 1);
            sd[k] = sv[k] ? src[k][0] : 8'($urandom);
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("g%0d_ready", gap_of(k)), rdy[k], (mq[k].size() < DEPTH) ? 1 : 0);
            push[k] = sv[k] && (mq[k].size() < DEPTH);
            if (!rdy[k]) full_seen[k]++;
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (mq[k].size() > 0 && idle_run[k] >= gap_of(k)) begin
                exp_dv[k]   = 1'b1;
                exp_dd[k]   = mq[k].pop_front();
                idle_run[k] = 0;
                exp_sent[k]++;
            end else begin
                exp_dv[k] = 1'b0;
                exp_dd[k] = 8'h00;
                if (idle_run[k] < 100) idle_run[k]++;
            end
            if (push[k]) begin
                mq[k].push_back(sd[k]);
                void'(src[k].pop_front());
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("g%0d_valid", gap_of(k)), dv[k], exp_dv[k]);
            chk($sformatf("g%0d_data", gap_of(k)), dd[k], exp_dd[k]);
            chk($sformatf("g%0d_sent", gap_of(k)), sent_of(k), exp_sent[k] % (1 << cw_of(k)));
            chk($sformatf("g%0d_busy", gap_of(k)), bz[k],
                (mq[k].size() != 0 || idle_run[k] <= gap_of(k)) ? 1 : 0);
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (n < bound && !all_idle()) begin
            step();
            n++;
        end
        chk("drain_done", all_idle(), 1);
    endtask

    task automatic check_sent(input string tag, input int beats);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_g%0d_sent", tag, gap_of(k)), sent_of(k), beats % (1 << cw_of(k)));
            chk($sformatf("%s_g%0d_idle", tag, gap_of(k)), bz[k], 0);
        end
    endtask

    initial begin
        int n;
        model_reset();
        for (int k = 0; k < 3; k++) full_seen[k] = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("rst_hold");
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_rel_g%0d_ready", gap_of(k)), rdy[k], 1);
            chk($sformatf("rst_rel_g%0d_valid", gap_of(k)), dv[k], 0);
        end
        repeat (3) step();

        for (int k = 0; k < 3; k++) src[k].push_back(8'hA5);
        drain(50);
        check_sent("single", 1);

        for (int k = 0; k < 3; k++) for (int i = 1; i <= 4; i++) src[k].push_back(8'(i));
        drain(100);
        check_sent("stream", 5);

        for (int k = 0; k < 3; k++) full_seen[k] = 0;
        for (int k = 0; k < 3; k++) for (int i = 0; i < 8; i++) src[k].push_back(8'(8'h20 + i));
        drain(200);
        chk("g2_backpressure_seen", (full_seen[1] > 0) ? 1 : 0, 1);
        check_sent("backpressure", 13);

        // 16 beats in total: the 4-bit counter of the GAP=0 instance wraps to 0 here.
        for (int k = 0; k < 3; k++) for (int i = 0; i < 3; i++) src[k].push_back(8'(8'h10 + i));
        drain(100);
        check_sent("b2b_wrap", 16);

        rand_mode = 1'b1;
        for (int k = 0; k < 3; k++) repeat (40) src[k].push_back(8'($urandom));
        drain(2000);
        rand_mode = 1'b0;
        check_sent("random", 56);

        for (int k = 0; k < 3; k++) for (int i = 0; i < 4; i++) src[k].push_back(8'(8'h30 + i));
        n = 0;
        while (!(dv[0] && mq[0].size() == 2) && n < 20) begin
            step();
            n++;
        end
        chk("mid_rst_reached", (dv[0] && mq[0].size() == 2) ? 1 : 0, 1);
        rst = 1'b1;
        #1;
        check_zero("mid_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("post_rst_g%0d_ready", gap_of(k)), rdy[k], 1);
        for (int k = 0; k < 3; k++) src[k].push_back(8'h5A);
        drain(50);
        repeat (6) step();
        check_sent("post_rst", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
